adc12_sample_buffer: RTL and testbench

Downstream consumer of the 12-bit SAR ADC controller's user-side VALID/VALUE strobe. Optionally averages 1/2/4/8 consecutive conversions, selected by config bits. Pushes each averaged word into a small first-word-fall-through FIFO. The user design drains the FIFO with a pop strobe, and overflow is flagged sticky.

---
 rtl/adc12_pkg.sv | 16 +
 rtl/sync_fifo_fwft.sv | 78 +++++++
 rtl/adc12_sample_buffer.sv | 136 +++++++++++++
 tb/tb_adc12_sample_buffer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc12_pkg.sv
// Shared constants and types for the 12-bit ADC sample buffer.
// Holds the averaging selector encoding and the accumulator sizing.
package adc12_pkg;

  localparam int ADC_NUM_BITS = 12;
  localparam int AVG_LOG2_MAX = 3;
  localparam int ACC_W        = ADC_NUM_BITS + AVG_LOG2_MAX;

  typedef enum logic [1:0] {
    AVG_1 = 2'd0,
    AVG_2 = 2'd1,
    AVG_4 = 2'd2,
    AVG_8 = 2'd3
  } avg_sel_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
// A push while full without a pop is dropped and reported on 'drop'.
module sync_fifo_fwft #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                       UserCLK,
  input  logic                       RESET_N,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_pop_s;
  logic             do_push_s;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;
  assign dout  = empty ? {WIDTH{1'b0}} : mem_q[rd_q[AW-1:0]];

  // Pointer next-state; a pop only counts when a word is present, which frees a slot for a same-cycle push.
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    drop      = 1'b0;
    wr_d      = wr_q;
    rd_d      = rd_q;
    if (flush) begin
      wr_d = {(AW+1){1'b0}};
      rd_d = {(AW+1){1'b0}};
    end else begin
      do_pop_s  = pop && !empty;
      do_push_s = push && (!full || do_pop_s);
      drop      = push && full && !pop;
      if (do_pop_s) begin
        rd_d = rd_q + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_d = rd_q;
      end
      if (do_push_s) begin
        wr_d = wr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_d = wr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge UserCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_q <= {(AW+1){1'b0}};
      rd_q <= {(AW+1){1'b0}};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; intentionally left out of reset.
  always_ff @(posedge UserCLK) begin
    if (do_push_s) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/adc12_sample_buffer.sv
// Averages 1/2/4/8 consecutive ADC conversions and queues each result in a FWFT FIFO.
// The averaging factor is captured on the first sample of every group.
module adc12_sample_buffer
  import adc12_pkg::*;
#(
  parameter int NUM_BITS     = 12,
  parameter int DEPTH        = 8,
  parameter int NoConfigBits = 2
) (
  input  logic                     UserCLK,
  input  logic                     RESET_N,
  input  logic                     CLEAR,
  input  logic                     SAMPLE_VALID,
  input  logic [NUM_BITS-1:0]      SAMPLE_VALUE,
  input  logic                     POP,
  output logic [NUM_BITS-1:0]      DATA,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVERFLOW,
  input  logic [NoConfigBits-1:0]  ConfigBits
);

  localparam int SUM_W = NUM_BITS + AVG_LOG2_MAX;

  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [2:0]          cnt_q, cnt_d;
  avg_sel_t            sel_q, sel_d;
  avg_sel_t            sel_s;
  logic [2:0]          last_s;
  logic [SUM_W-1:0]    sum_s;
  logic [NUM_BITS-1:0] avg_s;
  logic                push_s;
  logic                drop_s;
  logic                overflow_q, overflow_d;

  assign sum_s    = acc_q + {{AVG_LOG2_MAX{1'b0}}, SAMPLE_VALUE};
  assign OVERFLOW = overflow_q;

  // Selects the group length and the truncated average for the active group.
  always_comb begin
    if (cnt_q == 3'd0) begin
      sel_s = avg_sel_t'(ConfigBits[1:0]);
    end else begin
      sel_s = sel_q;
    end
    case (sel_s)
      AVG_1: begin
        last_s = 3'd0;
        avg_s  = sum_s[NUM_BITS-1:0];
      end
      AVG_2: begin
        last_s = 3'd1;
        avg_s  = sum_s[NUM_BITS:1];
      end
      AVG_4: begin
        last_s = 3'd3;
        avg_s  = sum_s[NUM_BITS+1:2];
      end
      AVG_8: begin
        last_s = 3'd7;
        avg_s  = sum_s[NUM_BITS+2:3];
      end
      default: begin
        last_s = 3'd0;
        avg_s  = sum_s[NUM_BITS-1:0];
      end
    endcase
  end

  // Accumulator, group counter and overflow sticky next-state; CLEAR wins over everything.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    push_s     = 1'b0;
    overflow_d = overflow_q;
    if (CLEAR) begin
      acc_d      = {SUM_W{1'b0}};
      cnt_d      = 3'd0;
      overflow_d = 1'b0;
    end else begin
      if (SAMPLE_VALID) begin
        sel_d = sel_s;
        if (cnt_q == last_s) begin
          push_s = 1'b1;
          acc_d  = {SUM_W{1'b0}};
          cnt_d  = 3'd0;
        end else begin
          acc_d  = sum_s;
          cnt_d  = cnt_q + 3'd1;
        end
      end else begin
        sel_d = sel_q;
      end
      if (drop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // Averaging and sticky state registers.
  always_ff @(posedge UserCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc_q      <= {SUM_W{1'b0}};
      cnt_q      <= 3'd0;
      sel_q      <= AVG_1;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (NUM_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .UserCLK (UserCLK),
    .RESET_N (RESET_N),
    .flush   (CLEAR),
    .push    (push_s),
    .din     (avg_s),
    .pop     (POP),
    .dout    (DATA),
    .empty   (EMPTY),
    .full    (FULL),
    .level   (LEVEL),
    .drop    (drop_s)
  );

endmodule

// File: tb/tb_adc12_sample_buffer.sv
// Self-checking bench for adc12_sample_buffer: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_adc12_sample_buffer;

  localparam int NB = 12;
  localparam int DP = 8;

  logic          clk;
  logic          RESET_N;
  logic          CLEAR;
  logic          SAMPLE_VALID;
  logic [NB-1:0] SAMPLE_VALUE;
  logic          POP;
  logic [1:0]    cfg;
  logic [NB-1:0] DATA;
  logic          EMPTY;
  logic          FULL;
  logic [3:0]    LEVEL;
  logic          OVERFLOW;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state
  int unsigned mq[$];
  int unsigned m_acc;
  int          m_cnt;
  int          m_sel;
  bit          m_ov;

  adc12_sample_buffer #(.NUM_BITS(NB), .DEPTH(DP), .NoConfigBits(2)) dut (
    .UserCLK      (clk),
    .RESET_N      (RESET_N),
    .CLEAR        (CLEAR),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_VALUE (SAMPLE_VALUE),
    .POP          (POP),
    .DATA         (DATA),
    .EMPTY        (EMPTY),
    .FULL         (FULL),
    .LEVEL        (LEVEL),
    .OVERFLOW     (OVERFLOW),
    .ConfigBits   (cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_acc = 0;
    m_cnt = 0;
    m_sel = 0;
    m_ov  = 1'b0;
  endfunction

  // One clock edge of the specified behaviour, using the inputs currently applied.
  function automatic void model_step();
    bit          have_word;
    int unsigned word;
    bit          pop_ok;
    have_word = 1'b0;
    word      = 0;
    if (CLEAR) begin
      model_reset();
      return;
    end
    if (SAMPLE_VALID) begin
      if (m_cnt == 0) m_sel = int'(cfg);
      m_acc += int'(SAMPLE_VALUE);
      m_cnt++;
      if (m_cnt == (1 << m_sel)) begin
        have_word = 1'b1;
        word      = m_acc >> m_sel;
        m_acc     = 0;
        m_cnt     = 0;
      end
    end
    pop_ok = POP && (mq.size() > 0);
    if (have_word && mq.size() == DP && !POP) begin
      m_ov = 1'b1;
      have_word = 1'b0;
    end
    if (pop_ok) void'(mq.pop_front());
    if (have_word) mq.push_back(word);
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("DATA",     DATA,     (mq.size() > 0) ? mq[0] : 0);
      check("EMPTY",    EMPTY,    mq.size() == 0);
      check("FULL",     FULL,     mq.size() == DP);
      check("LEVEL",    LEVEL,    mq.size());
      check("OVERFLOW", OVERFLOW, m_ov);
    end
  end

  task automatic cyc(input logic cl, input logic v, input logic [NB-1:0] val,
                     input logic p, input logic [1:0] c);
    CLEAR        = cl;
    SAMPLE_VALID = v;
    SAMPLE_VALUE = val;
    POP          = p;
    cfg          = c;
    @(posedge clk);
    if (RESET_N) model_step();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic smp(input logic [NB-1:0] val, input logic [1:0] c);
    cyc(1'b0, 1'b1, val, 1'b0, c);
  endtask

  task automatic pop1();
    cyc(1'b0, 1'b0, 12'h000, 1'b1, cfg);
  endtask

  initial begin
    RESET_N = 1'b0;
    CLEAR = 1'b0; SAMPLE_VALID = 1'b0; SAMPLE_VALUE = 12'h000; POP = 1'b0; cfg = 2'd0;
    model_reset();
    @(negedge clk);
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 2'd0);
    check("rst_empty", EMPTY, 1);
    check("rst_level", LEVEL, 0);
    check("rst_data",  DATA, 0);
    RESET_N = 1'b1;
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 2'd0);

    // Pass-through and FWFT order
    smp(12'h123, 2'd0); smp(12'hABC, 2'd0); smp(12'hFFF, 2'd0);
    check("pt_level", LEVEL, 3);
    check("pt_data0", DATA, 12'h123);
    pop1(); check("pt_data1", DATA, 12'hABC);
    pop1(); check("pt_data2", DATA, 12'hFFF);
    pop1(); check("pt_empty", EMPTY, 1);

    // Averaging by 4 and by 8
    smp(12'h100, 2'd2); smp(12'h200, 2'd2); smp(12'h300, 2'd2);
    check("avg4_nopush", EMPTY, 1);
    smp(12'h401, 2'd2);
    check("avg4_data", DATA, 12'h280);
    check("avg4_level", LEVEL, 1);
    pop1();
    for (int i = 0; i < 8; i++) smp(12'hFFF, 2'd3);
    check("avg8_data", DATA, 12'hFFF);
    pop1();

    // Overflow
    for (int i = 1; i <= 9; i++) begin
      smp(NB'(i), 2'd0);
      if (i == 8) check("ovf_full8", FULL, 1);
    end
    check("ovf_sticky", OVERFLOW, 1);
    check("ovf_level", LEVEL, 8);
    for (int i = 1; i <= 8; i++) begin
      check("ovf_drain", DATA, i);
      pop1();
    end
    check("ovf_hold", OVERFLOW, 1);
    cyc(1'b1, 1'b0, 12'h000, 1'b0, 2'd0);
    check("ovf_clear", OVERFLOW, 0);

    // Push+pop while full, then while empty
    for (int i = 0; i < 8; i++) smp(NB'(12'h010 + i), 2'd0);
    cyc(1'b0, 1'b1, 12'h055, 1'b1, 2'd0);
    check("pp_full_level", LEVEL, 8);
    check("pp_full_ovf", OVERFLOW, 0);
    for (int i = 0; i < 7; i++) pop1();
    check("pp_full_last", DATA, 12'h055);
    pop1();
    cyc(1'b0, 1'b1, 12'h077, 1'b1, 2'd0);
    check("pp_empty_level", LEVEL, 1);
    check("pp_empty_data", DATA, 12'h077);
    pop1();

    // Config latched at group start
    smp(12'h010, 2'd1); smp(12'h030, 2'd3);
    check("latch_data", DATA, 12'h020);
    smp(12'h008, 2'd3);
    for (int i = 0; i < 6; i++) smp(12'h008, 2'd0);
    check("latch_wait8", LEVEL, 1);
    smp(12'h008, 2'd0);
    check("latch_grp8", LEVEL, 2);
    pop1();
    check("latch_avg8", DATA, 12'h008);
    pop1();

    // CLEAR mid-group discards the sample and partial sum
    smp(12'h800, 2'd2); smp(12'h800, 2'd2);
    cyc(1'b1, 1'b1, 12'h800, 1'b0, 2'd2);
    check("clr_empty", EMPTY, 1);
    for (int i = 0; i < 4; i++) smp(12'h004, 2'd2);
    check("clr_avg", DATA, 12'h004);
    pop1();

    // Asynchronous reset with three words queued
    smp(12'h001, 2'd0); smp(12'h002, 2'd0); smp(12'h003, 2'd0);
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    check("arst_empty", EMPTY, 1);
    check("arst_level", LEVEL, 0);
    check("arst_data",  DATA, 0);
    cyc(1'b0, 1'b1, 12'h3AA, 1'b0, 2'd0);
    RESET_N = 1'b1;
    cyc(1'b0, 1'b0, 12'h000, 1'b0, 2'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(1) == 1), NB'($urandom),
          ($urandom_range(2) == 0), 2'($urandom));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
